// File: rtl/fp_cmp_arbiter.sv
// fp_cmp_arbiter: shares one combinational FP comparator between two
// requesters. Round-robin grant, one registered operand stage feeding the
// comparator, one registered response stage tagged with the requester ID,
// and a sticky invalid-operation flag for the FP CSR.
module fp_cmp_arbiter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic [1:0]            in_req_valid,
    output logic [1:0]            out_req_ready,
    input  logic [DATA_WIDTH-1:0] in_req0_numA,
    input  logic [DATA_WIDTH-1:0] in_req0_numB,
    input  logic [DATA_WIDTH-1:0] in_req1_numA,
    input  logic [DATA_WIDTH-1:0] in_req1_numB,
    input  logic [1:0]            in_req0_cmp_type,
    input  logic [1:0]            in_req1_cmp_type,
    input  logic                  in_req0_fmt,
    input  logic                  in_req1_fmt,
    output logic [DATA_WIDTH-1:0] out_cmp_numA,
    output logic [DATA_WIDTH-1:0] out_cmp_numB,
    output logic [1:0]            out_cmp_type,
    output logic                  out_cmp_fmt,
    input  logic [DATA_WIDTH-1:0] in_cmp_data,
    input  logic                  in_cmp_flag_NV,
    output logic                  out_rsp_valid,
    input  logic                  in_rsp_ready,
    output logic                  out_rsp_id,
    output logic [DATA_WIDTH-1:0] out_rsp_data,
    output logic                  out_rsp_NV,
    input  logic                  in_nv_clr,
    output logic                  out_nv_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic                    last_grant;
    logic [1:0]              grant;
    logic                    accept_window;
    logic [1:0]              ready;
    logic                    accept;
    logic                    accept_id;
    logic                    capture;

    logic                    op_id;
    logic                    rsp_id;
    logic                    rsp_nv;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    nv_sticky;

    logic [DATA_WIDTH-1:0]   cmp_a;
    logic [DATA_WIDTH-1:0]   cmp_b;
    logic [1:0]              cmp_type;
    logic                    cmp_fmt;

    // Round-robin grant: a lone requester always wins; under contention the
    // requester that did not win last time is chosen.
    always_comb begin
        grant = 2'b00;
        case (in_req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // A new request can enter when idle, or in the same cycle the pending
    // response is consumed, which gives back-to-back operation.
    assign accept_window = (state == IDLE) || ((state == RESP) && in_rsp_ready);
    assign ready         = grant & {2{accept_window}};
    assign accept        = |(in_req_valid & ready);
    assign accept_id     = ready[1];
    assign capture       = (state == CMP);

    // FSM state register.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: CMP lasts exactly one cycle, RESP waits for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CMP;
                end
            end
            CMP: begin
                state_next = RESP;
            end
            RESP: begin
                if (in_rsp_ready) begin
                    state_next = accept ? CMP : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Remember the last winner so contention alternates between requesters;
    // reset value 1 lets requester 0 win first.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= accept_id;
        end
    end

    // Operand stage: latch the granted request; these registers drive the
    // comparator directly and hold their value outside CMP.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cmp_a    <= '0;
            cmp_b    <= '0;
            cmp_type <= 2'b00;
            cmp_fmt  <= 1'b0;
            op_id    <= 1'b0;
        end else if (accept) begin
            cmp_a    <= accept_id ? in_req1_numA     : in_req0_numA;
            cmp_b    <= accept_id ? in_req1_numB     : in_req0_numB;
            cmp_type <= accept_id ? in_req1_cmp_type : in_req0_cmp_type;
            cmp_fmt  <= accept_id ? in_req1_fmt      : in_req0_fmt;
            op_id    <= accept_id;
        end
    end

    // Response stage: capture the comparator result at the end of CMP; the
    // values hold through any backpressure in RESP.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rsp_data <= '0;
            rsp_nv   <= 1'b0;
            rsp_id   <= 1'b0;
        end else if (capture) begin
            rsp_data <= in_cmp_data;
            rsp_nv   <= in_cmp_flag_NV;
            rsp_id   <= op_id;
        end
    end

    // Sticky NV: a capture raising NV takes precedence over a simultaneous clear.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            nv_sticky <= 1'b0;
        end else if (capture && in_cmp_flag_NV) begin
            nv_sticky <= 1'b1;
        end else if (in_nv_clr) begin
            nv_sticky <= 1'b0;
        end
    end

    assign out_req_ready = ready;
    assign out_cmp_numA  = cmp_a;
    assign out_cmp_numB  = cmp_b;
    assign out_cmp_type  = cmp_type;
    assign out_cmp_fmt   = cmp_fmt;
    assign out_rsp_valid = (state == RESP);
    assign out_rsp_id    = rsp_id;
    assign out_rsp_data  = rsp_data;
    assign out_rsp_NV    = rsp_nv;
    assign out_nv_sticky = nv_sticky;

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Directed bench for fp_cmp_arbiter with a behavioural FP comparator
// attached to the comparator port.
module tb_fp_cmp_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_t, req1_t;
    logic        req0_f, req1_f;
    logic [63:0] cmp_a, cmp_b;
    logic [1:0]  cmp_t;
    logic        cmp_f;
    logic [63:0] cmp_data;
    logic        cmp_nv;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_data;
    logic        rsp_nv;
    logic        nv_clr;
    logic        nv_sticky;

    int n_vec;
    int n_err;

    localparam logic [63:0] D_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] D_TWO  = 64'h4000000000000000;
    localparam logic [63:0] D_MONE = 64'hBFF0000000000000;
    localparam logic [63:0] D_QNAN = 64'h7FF8000000000000;
    localparam logic [63:0] S_ONE  = 64'h000000003F800000;
    localparam logic [63:0] S_QNAN = 64'h000000007FC00000;

    fp_cmp_arbiter #(.DATA_WIDTH(64)) dut (
        .in_clk           (clk),
        .in_rst_n         (rst_n),
        .in_req_valid     (req_valid),
        .out_req_ready    (req_ready),
        .in_req0_numA     (req0_a),
        .in_req0_numB     (req0_b),
        .in_req1_numA     (req1_a),
        .in_req1_numB     (req1_b),
        .in_req0_cmp_type (req0_t),
        .in_req1_cmp_type (req1_t),
        .in_req0_fmt      (req0_f),
        .in_req1_fmt      (req1_f),
        .out_cmp_numA     (cmp_a),
        .out_cmp_numB     (cmp_b),
        .out_cmp_type     (cmp_t),
        .out_cmp_fmt      (cmp_f),
        .in_cmp_data      (cmp_data),
        .in_cmp_flag_NV   (cmp_nv),
        .out_rsp_valid    (rsp_valid),
        .in_rsp_ready     (rsp_ready),
        .out_rsp_id       (rsp_id),
        .out_rsp_data     (rsp_data),
        .out_rsp_NV       (rsp_nv),
        .in_nv_clr        (nv_clr),
        .out_nv_sticky    (nv_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural comparator: returns {nv, result}. Any NaN flags NV and
    // yields 0; the reserved type yields 0.
    function automatic logic [1:0] fp_cmp(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] t, input logic f);
        logic        sa, sb, na, nb, lt, eq;
        logic [62:0] ma, mb;
        if (f) begin
            sa = a[63]; sb = b[63];
            ma = a[62:0]; mb = b[62:0];
            na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
            nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        end else begin
            sa = a[31]; sb = b[31];
            ma = {32'd0, a[30:0]}; mb = {32'd0, b[30:0]};
            na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
            nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        end
        eq = ((ma == mb) && (sa == sb)) || ((ma == 63'd0) && (mb == 63'd0));
        if ((ma == 63'd0) && (mb == 63'd0)) lt = 1'b0;
        else if (sa != sb)                  lt = sa;
        else if (!sa)                       lt = (ma < mb);
        else                                lt = (ma > mb);
        if (t == 2'b11)     return 2'b00;
        if (na || nb)       return 2'b10;
        case (t)
            2'b10:   return {1'b0, eq};
            2'b01:   return {1'b0, lt};
            default: return {1'b0, lt | eq};
        endcase
    endfunction

    logic [1:0] model_out;
    assign model_out = fp_cmp(cmp_a, cmp_b, cmp_t, cmp_f);
    assign cmp_data  = {63'd0, model_out[0]};
    assign cmp_nv    = model_out[1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Raise valid for one requester, wait (bounded) for ready, let the accept
    // edge pass and drop valid. Returns at the negedge inside CMP.
    task automatic issue(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] t, input logic f);
        bit got;
        got = 1'b0;
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_t = t; req0_f = f;
        end else begin
            req1_a = a; req1_b = b; req1_t = t; req1_f = f;
        end
        req_valid[id] = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            if (req_ready[id]) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) chk("issue_timeout", 64'd0, 64'd1);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    // Consume the pending response in one cycle.
    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; nv_clr = 1'b0;
        req0_a = '0; req0_b = '0; req0_t = 2'b00; req0_f = 1'b0;
        req1_a = '0; req1_b = '0; req1_t = 2'b00; req1_f = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_sticky",    {63'd0, nv_sticky}, 64'd0);
        chk("rst_cmp_a",     cmp_a, 64'd0);
        chk("rst_rsp_data",  rsp_data, 64'd0);
        chk("rst_rsp_id",    {63'd0, rsp_id}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: 1.0 < 2.0 double, two-edge latency
        req0_a = D_ONE; req0_b = D_TWO; req0_t = 2'b01; req0_f = 1'b1;
        req_valid = 2'b01;
        #1 chk("single_ready", {62'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("single_cmp_a",     cmp_a, D_ONE);
        chk("single_cmp_b",     cmp_b, D_TWO);
        chk("single_cmp_type",  {62'd0, cmp_t}, 64'd1);
        chk("single_early_vld", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        chk("single_vld",  {63'd0, rsp_valid}, 64'd1);
        chk("single_data", rsp_data, 64'd1);
        chk("single_id",   {63'd0, rsp_id}, 64'd0);
        chk("single_nv",   {63'd0, rsp_nv}, 64'd0);
        handshake();
        chk("single_idle", {63'd0, rsp_valid}, 64'd0);

        // NaN single-precision EQ from requester 1
        issue(1, S_QNAN, S_ONE, 2'b10, 1'b0);
        @(negedge clk);
        chk("nan_vld",    {63'd0, rsp_valid}, 64'd1);
        chk("nan_data",   rsp_data, 64'd0);
        chk("nan_nv",     {63'd0, rsp_nv}, 64'd1);
        chk("nan_id",     {63'd0, rsp_id}, 64'd1);
        chk("nan_sticky", {63'd0, nv_sticky}, 64'd1);
        handshake();
        // Clear on the same edge as a second NaN capture: set wins
        issue(1, S_QNAN, S_ONE, 2'b10, 1'b0);
        nv_clr = 1'b1;
        @(negedge clk);
        nv_clr = 1'b0;
        chk("nan_clr_set_wins", {63'd0, nv_sticky}, 64'd1);
        chk("nan2_nv",          {63'd0, rsp_nv}, 64'd1);
        handshake();
        nv_clr = 1'b1;
        @(negedge clk);
        nv_clr = 1'b0;
        chk("nv_clear", {63'd0, nv_sticky}, 64'd0);

        // Contention: grants alternate 0,1,0,1 back-to-back
        req0_a = D_ONE; req0_b = D_TWO; req0_t = 2'b01; req0_f = 1'b1;
        req1_a = D_TWO; req1_b = D_ONE; req1_t = 2'b01; req1_f = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1 chk("cont_first_ready", {62'd0, req_ready}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 chk("cont_cmp_ready", {62'd0, req_ready}, 64'd0);
            @(negedge clk);
            chk("cont_vld",  {63'd0, rsp_valid}, 64'd1);
            chk("cont_id",   {63'd0, rsp_id}, 64'(k % 2));
            chk("cont_data", rsp_data, (k % 2 == 0) ? 64'd1 : 64'd0);
            if (k == 3) req_valid = 2'b00;
            #1 chk("cont_next_ready", {62'd0, req_ready},
                   (k == 3) ? 64'd0 : ((k % 2 == 0) ? 64'd2 : 64'd1));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("cont_idle", {63'd0, rsp_valid}, 64'd0);

        // Backpressure: -1.0 < 0.0, response held for 5 cycles
        issue(0, D_MONE, 64'd0, 2'b01, 1'b1);
        req1_a = D_ONE; req1_b = D_ONE; req1_t = 2'b10; req1_f = 1'b1;
        req_valid[1] = 1'b1;
        #1 chk("bp_cmp_ready", {62'd0, req_ready}, 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("bp_vld",   {63'd0, rsp_valid}, 64'd1);
            chk("bp_data",  rsp_data, 64'd1);
            chk("bp_id",    {63'd0, rsp_id}, 64'd0);
            chk("bp_nv",    {63'd0, rsp_nv}, 64'd0);
            chk("bp_ready", {62'd0, req_ready}, 64'd0);
        end
        req_valid = 2'b00;
        handshake();
        chk("bp_idle", {63'd0, rsp_valid}, 64'd0);
        handshake();
        chk("bp_ready_ignored", {63'd0, rsp_valid}, 64'd0);

        // Equal / LE / reserved, single 1.0 vs 1.0
        for (int k = 0; k < 3; k++) begin
            logic [1:0] t;
            t = (k == 0) ? 2'b00 : ((k == 1) ? 2'b10 : 2'b11);
            issue(0, S_ONE, S_ONE, t, 1'b0);
            chk("eq_cmp_type", {62'd0, cmp_t}, {62'd0, t});
            chk("eq_cmp_fmt",  {63'd0, cmp_f}, 64'd0);
            @(negedge clk);
            chk("eq_data", rsp_data, (k == 2) ? 64'd0 : 64'd1);
            chk("eq_nv",   {63'd0, rsp_nv}, 64'd0);
            handshake();
        end

        // Reset while in CMP
        issue(0, D_QNAN, D_ONE, 2'b01, 1'b1);
        @(negedge clk);
        chk("rc_pre_sticky", {63'd0, nv_sticky}, 64'd1);
        handshake();
        issue(0, D_ONE, D_TWO, 2'b01, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rc_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rc_sticky",    {63'd0, nv_sticky}, 64'd0);
        chk("rc_cmp_a",     cmp_a, 64'd0);
        @(negedge clk);
        chk("rc_no_rsp", {63'd0, rsp_valid}, 64'd0);
        rst_n = 1'b1;
        req1_a = D_TWO; req1_b = D_ONE; req1_t = 2'b01; req1_f = 1'b1;
        req_valid = 2'b11;
        #1 chk("rc_ready", {62'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("rc_vld",  {63'd0, rsp_valid}, 64'd1);
        chk("rc_id",   {63'd0, rsp_id}, 64'd0);
        chk("rc_data", rsp_data, 64'd1);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
